// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: shared types and select codes
// for the EX-stage forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam int NB_REG_P = 5;

  // Operand mux selects: register file, EX/MEM, MEM/WB.
  localparam logic [1:0] FWD_SEL_REG = 2'b00;
  localparam logic [1:0] FWD_SEL_MEM = 2'b01;
  localparam logic [1:0] FWD_SEL_WB  = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } stall_st_t;

  // One slot of the destination-tracking shadow pipe.
  typedef struct packed {
    logic                valid;
    logic [NB_REG_P-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_t;

  // The youngest producer wins: EX before MEM.
  function automatic logic [1:0] pick_sel(
    input logic hit_ex,
    input logic hit_mem
  );
    logic [1:0] s;
    s = FWD_SEL_REG;
    unique case (1'b1)
      hit_ex:               s = FWD_SEL_MEM;
      (hit_mem && !hit_ex): s = FWD_SEL_WB;
      default:              s = FWD_SEL_REG;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// fwd_src_cmp: compares one ID source register against
// the EX and MEM shadow slots; yields select and load-use hit.
module fwd_src_cmp
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NB_REG = NB_REG_P
) (
  input  logic [NB_REG-1:0] src,
  input  logic              use_src,
  input  logic              ex_valid,
  input  logic [NB_REG-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              mem_valid,
  input  logic [NB_REG-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        sel,
  output logic              lu_hit
);

  logic live;
  logic ex_eq;
  logic hit_ex;
  logic hit_mem;

  // r0 is hard-wired zero, so it never needs forwarding.
  assign live    = use_src && (src != '0);
  assign ex_eq   = live && ex_valid && (ex_rd == src);
  assign hit_ex  = ex_eq && ex_reg_write;
  assign hit_mem = live && mem_valid && mem_reg_write
                   && (mem_rd == src);

  assign sel    = pick_sel(hit_ex, hit_mem);
  assign lu_hit = ex_eq && ex_mem_read;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects and load-use
// stall/bubble control. Optional counters: FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NB_REG = NB_REG_P,
  parameter int NB_SEL = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [NB_REG-1:0] i_id_rd,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  output logic [NB_SEL-1:0] o_fwd_a_sel,
  output logic [NB_SEL-1:0] o_fwd_b_sel,
  output logic              o_stall,
  output logic              o_bubble
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_fwd_cnt
`endif
);

  stage_t    ex_q;
  stage_t    mem_q;
  stage_t    wb_q;
  stage_t    id_e;
  stall_st_t state_q;

  logic       use_a;
  logic       use_b;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       lu_a;
  logic       lu_b;
  logic       lu_any;
  logic       squash;
  logic [1:0] sel_a_d;
  logic [1:0] sel_b_d;

  // An invalid ID slot reads nothing and writes nothing.
  assign use_a = i_id_valid && i_id_use_rs;
  assign use_b = i_id_valid && i_id_use_rt;

  // Invalid slots carry all-zero fields.
  always_comb begin
    id_e           = '0;
    id_e.valid     = i_id_valid;
    id_e.rd        = i_id_valid ? i_id_rd : '0;
    id_e.reg_write = i_id_valid && i_id_reg_write;
    id_e.mem_read  = i_id_valid && i_id_mem_read;
  end

  fwd_src_cmp #(.NB_REG(NB_REG)) u_cmp_rs (
    .src           (i_id_rs),
    .use_src       (use_a),
    .ex_valid      (ex_q.valid),
    .ex_rd         (ex_q.rd),
    .ex_reg_write  (ex_q.reg_write),
    .ex_mem_read   (ex_q.mem_read),
    .mem_valid     (mem_q.valid),
    .mem_rd        (mem_q.rd),
    .mem_reg_write (mem_q.reg_write),
    .sel           (sel_a),
    .lu_hit        (lu_a)
  );

  fwd_src_cmp #(.NB_REG(NB_REG)) u_cmp_rt (
    .src           (i_id_rt),
    .use_src       (use_b),
    .ex_valid      (ex_q.valid),
    .ex_rd         (ex_q.rd),
    .ex_reg_write  (ex_q.reg_write),
    .ex_mem_read   (ex_q.mem_read),
    .mem_valid     (mem_q.valid),
    .mem_rd        (mem_q.rd),
    .mem_reg_write (mem_q.reg_write),
    .sel           (sel_b),
    .lu_hit        (lu_b)
  );

  // Flush beats load-use: the bubble still goes in,
  // but the PC is free to redirect.
  assign lu_any   = lu_a || lu_b;
  assign o_stall  = i_enable && lu_any && !i_flush;
  assign o_bubble = i_enable && lu_any;
  assign squash   = lu_any || i_flush;

  // A squashed slot enters EX as a NOP, so it needs no select.
  assign sel_a_d = squash ? FWD_SEL_REG : sel_a;
  assign sel_b_d = squash ? FWD_SEL_REG : sel_b;

  // Shadow pipe advances in lockstep with ID/EX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (i_enable) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= squash ? '0 : id_e;
    end
  end

  // Selects are registered with the instruction entering EX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fwd_a_sel <= '0;
      o_fwd_b_sel <= '0;
    end else if (i_enable) begin
      o_fwd_a_sel <= sel_a_d;
      o_fwd_b_sel <= sel_b_d;
    end
  end

  // Stall FSM: one stall cycle per load-use, then back to RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
    end else if (i_enable) begin
      unique case (state_q)
        ST_RUN:      if (o_stall) state_q <= ST_LU_STALL;
        ST_LU_STALL: state_q <= ST_RUN;
      endcase
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  // Debug counters; both wrap naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_fwd_cnt   <= '0;
    end else if (i_enable) begin
      if (o_stall)
        o_stall_cnt <= o_stall_cnt + 32'd1;
      if ((sel_a_d != FWD_SEL_REG) || (sel_b_d != FWD_SEL_REG))
        o_fwd_cnt <= o_fwd_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // The stall bubble sits in EX, so stalls never chain;
  // bubbles leave no stale fields behind in WB.
  always_comb begin
    a_one_stall: assert (!((state_q == ST_LU_STALL) && lu_any));
    a_wb_clean:  assert (wb_q.valid || (wb_q == '0));
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed + random stimulus checked
// against an in-flight instruction queue model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en, flush, idv, urs, urt, wr, ld;
  logic [4:0] rs, rt, rd;
  logic [1:0] sa, sb;
  logic       stall, bubble;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } ins_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  ins_t     pipe[$];
  bit [1:0] m_sa, m_sb;
  bit       obs_stall, obs_bubble;
  logic [1:0] sa_hold;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .i_flush        (flush),
    .i_id_valid     (idv),
    .i_id_rs        (rs),
    .i_id_rt        (rt),
    .i_id_use_rs    (urs),
    .i_id_use_rt    (urt),
    .i_id_rd        (rd),
    .i_id_reg_write (wr),
    .i_id_mem_read  (ld),
    .o_fwd_a_sel    (sa),
    .o_fwd_b_sel    (sb),
    .o_stall        (stall),
    .o_bubble       (bubble)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ins_t e;
    e = '{default: 0};
    pipe.delete();
    repeat (3) pipe.push_back(e);
    m_sa = 2'b00;
    m_sb = 2'b00;
  endtask

  // Youngest older writer of src: EX -> 01, MEM -> 10.
  function automatic bit [1:0] ref_sel(bit [4:0] src, bit used);
    if (!(idv && used) || src == 0) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == src)
        return (k == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_lu();
    if (!idv || !pipe[0].v || !pipe[0].ld) return 1'b0;
    return (urs && rs != 0 && rs == pipe[0].rd) ||
           (urt && rt != 0 && rt == pipe[0].rd);
  endfunction

  task automatic ins(bit v, bit [4:0] d, bit w, bit l,
                     bit [4:0] s, bit [4:0] t, bit us, bit ut);
    idv = v; rd = d; wr = w; ld = l;
    rs = s; rt = t; urs = us; urt = ut;
    flush = 1'b0;
    en = 1'b1;
  endtask

  task automatic rand_inputs();
    idv   = ($urandom_range(0, 7) != 0);
    rs    = 5'($urandom_range(0, 3));
    rt    = 5'($urandom_range(0, 3));
    rd    = 5'($urandom_range(0, 3));
    urs   = 1'($urandom_range(0, 1));
    urt   = 1'($urandom_range(0, 1));
    wr    = ($urandom_range(0, 3) != 0);
    ld    = ($urandom_range(0, 2) == 0);
    flush = ($urandom_range(0, 9) == 0);
    en    = ($urandom_range(0, 9) != 0);
  endtask

  // One clock: check comb outputs mid-cycle, then selects after edge.
  task automatic cyc(string tag);
    bit   lu, sq;
    ins_t e;
    @(negedge clk);
    lu = ref_lu();
    obs_stall  = stall;
    obs_bubble = bubble;
    chk({tag, "/stall"},  stall,  en && lu && !flush);
    chk({tag, "/bubble"}, bubble, en && lu);
    if (en) begin
      sq   = lu || flush;
      e.v  = idv && !sq;
      e.rd = rd;
      e.wr = idv && wr;
      e.ld = idv && ld;
      m_sa = sq ? 2'b00 : ref_sel(rs, urs);
      m_sb = sq ? 2'b00 : ref_sel(rt, urt);
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
    @(posedge clk);
    #1;
    chk({tag, "/sel_a"}, sa, m_sa);
    chk({tag, "/sel_b"}, sb, m_sb);
  endtask

  initial begin
    model_reset();
    rand_inputs();
    // reset held with random inputs
    repeat (3) begin
      rand_inputs();
      @(negedge clk);
      chk("rst/sel_a", sa, 2'b00);
      chk("rst/sel_b", sb, 2'b00);
      chk("rst/stall", stall, 1'b0);
      chk("rst/bubble", bubble, 1'b0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();

    // EX forward: add r3,r1,r2 ; sub r5,r3,r4
    ins(1, 3, 1, 0, 1, 2, 1, 1); cyc("ex0");
    ins(1, 5, 1, 0, 3, 4, 1, 1); cyc("ex1");
    chk("ex_fwd_a", sa, 2'b01);
    chk("ex_fwd_b", sb, 2'b00);

    // MEM forward: add r3 ; nop ; or r6,r3,r3
    ins(1, 3, 1, 0, 1, 2, 1, 1); cyc("mem0");
    ins(0, 0, 0, 0, 0, 0, 0, 0); cyc("mem1");
    ins(1, 6, 1, 0, 3, 3, 1, 1); cyc("mem2");
    chk("mem_fwd_a", sa, 2'b10);
    chk("mem_fwd_b", sb, 2'b10);

    // priority: add r3 ; add r3 ; or r6,r3,r3
    ins(1, 3, 1, 0, 1, 2, 1, 1); cyc("pri0");
    ins(1, 3, 1, 0, 1, 2, 1, 1); cyc("pri1");
    ins(1, 6, 1, 0, 3, 3, 1, 1); cyc("pri2");
    chk("pri_fwd_a", sa, 2'b01);

    // load-use: lw r2 ; add r7,r2,r1
    ins(1, 2, 1, 1, 1, 0, 1, 0); cyc("lu0");
    ins(1, 7, 1, 0, 2, 1, 1, 1); cyc("lu1");
    chk("lu_stall", obs_stall, 1'b1);
    chk("lu_bubble", obs_bubble, 1'b1);
    chk("lu_sel_a", sa, 2'b00);
    cyc("lu2");
    chk("lu_stall_once", obs_stall, 1'b0);
    chk("lu_fwd_a", sa, 2'b10);

    // r0 writers never forward, loads to r0 never stall
    ins(1, 0, 1, 1, 1, 2, 1, 1); cyc("r0a");
    ins(1, 9, 1, 0, 0, 0, 1, 1); cyc("r0b");
    chk("r0_stall", obs_stall, 1'b0);
    chk("r0_sel_a", sa, 2'b00);
    chk("r0_sel_b", sb, 2'b00);

    // flush + load-use: lw r4 ; add r8,r4,r4 (flushed) ; rd r8,r4
    ins(1, 4, 1, 1, 1, 0, 1, 0); cyc("fl0");
    ins(1, 8, 1, 0, 4, 4, 1, 1); flush = 1'b1; cyc("fl1");
    chk("fl_stall", obs_stall, 1'b0);
    chk("fl_bubble", obs_bubble, 1'b1);
    ins(1, 11, 1, 0, 8, 4, 1, 1); cyc("fl2");
    chk("fl_sq_sel_a", sa, 2'b00);
    chk("fl_ld_sel_b", sb, 2'b10);

    // freeze during a pending load-use
    ins(1, 9, 1, 1, 0, 0, 0, 0); cyc("fz0");
    sa_hold = sa;
    ins(1, 10, 1, 0, 9, 1, 1, 1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc("fz");
      chk("fz_stall", obs_stall, 1'b0);
      chk("fz_sel_hold", sa, sa_hold);
    end
    en = 1'b1;
    cyc("fz5");
    chk("fz_stall_resume", obs_stall, 1'b1);
    cyc("fz6");
    chk("fz_fwd_a", sa, 2'b10);

    // async reset in the middle of a stall
    ins(1, 2, 1, 1, 1, 0, 1, 0); cyc("rm0");
    ins(1, 7, 1, 0, 2, 1, 1, 1);
    @(negedge clk);
    chk("rm_pre_stall", stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_stall", stall, 1'b0);
    chk("rm_bubble", bubble, 1'b0);
    chk("rm_sel_a", sa, 2'b00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("rm1");
    chk("rm_no_stall", obs_stall, 1'b0);

    // random traffic; a stalled ID instruction is usually re-presented
    for (int n = 0; n < 2000; n++) begin
      if (!obs_stall || $urandom_range(0, 3) == 0) begin
        rand_inputs();
      end else begin
        flush = ($urandom_range(0, 9) == 0);
        en    = ($urandom_range(0, 9) != 0);
      end
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequences the two 3-input operand multiplexers at the EX-stage ALU inputs (operand A, operand B).
- Tracks destination registers of in-flight instructions in an internal EX/MEM/WB shadow pipeline.
- Produces registered select codes and load-use stall/bubble control.
- Sits beside the ID/EX pipeline register and is clocked in lockstep with it.

Parameters:
- NB_REG, 5, register index width.
- NB_SEL, 2, select width; matches the operand multiplexers.

Ports:
- i_clk  input  1  pipeline clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  pipeline advance enable from debug unit; 0 freezes all state.
- i_flush  input  1  branch/jump taken; squashes the instruction currently in ID.
- i_id_valid  input  1  ID holds a real instruction.
- i_id_rs  input  NB_REG  source register A of ID instruction.
- i_id_rt  input  NB_REG  source register B of ID instruction.
- i_id_use_rs  input  1  ID instruction reads rs.
- i_id_use_rt  input  1  ID instruction reads rt.
- i_id_rd  input  NB_REG  destination register of ID instruction.
- i_id_reg_write  input  1  ID instruction writes the register file.
- i_id_mem_read  input  1  ID instruction is a load.
- o_fwd_a_sel  output  NB_SEL  operand A select, valid while the instruction is in EX.
- o_fwd_b_sel  output  NB_SEL  operand B select, valid while the instruction is in EX.
- o_stall  output  1  hold PC and IF/ID register.
- o_bubble  output  1  load NOP into the ID/EX register this cycle.

Behaviour:
- Reset (async, i_rst_n=0):
  - all shadow-stage valid bits 0; o_fwd_a_sel=o_fwd_b_sel=2'b00; o_stall=o_bubble=0.
- Shadow pipeline: entries EX, MEM, WB, each {valid, rd, reg_write, mem_read}.
  - On each i_clk rising edge with i_enable=1: WB<=MEM, MEM<=EX, EX<=ID entry.
  - The ID entry is replaced by an invalid entry when o_stall=1 or i_flush=1.
  - i_enable=0: all registers hold; o_stall and o_bubble forced 0.
- Hazard match: a source matches a stage when all of the following hold:
  - source used, and source != 0;
  - stage valid and stage reg_write;
  - stage rd == source.
- Select codes, computed in ID and registered into the outputs on the same edge as the ID/EX register:
  - match in EX -> 2'b01 (EX/MEM result);
  - else match in MEM -> 2'b10 (MEM/WB result);
  - else 2'b00 (register file). EX has priority.
  - The register file is write-before-read, so a WB-stage match needs no forwarding.
- Load-use (combinational from registered state plus ID inputs):
  - condition: EX valid, EX mem_read, and a used source matches EX rd (rd != 0).
  - Action: o_stall=1 and o_bubble=1 for exactly one cycle; the registered selects for that edge are 2'b00.
  - Next cycle the load is in MEM and the re-evaluated ID instruction gets 2'b10.
- Stall FSM: states RUN and LU_STALL.
  - RUN -> LU_STALL on a load-use condition with i_enable=1.
  - LU_STALL -> RUN unconditionally on the next enabled edge.
  - A second consecutive stall is impossible by construction; assert this in simulation.
- Simultaneous i_flush and load-use: flush wins; o_stall=0, o_bubble=1, the entry is squashed, and the FSM stays in RUN.
- i_id_valid=0: treated as not using any sources and not writing a register.
- Reset mid-stall: FSM returns to RUN immediately; outputs return to their reset values.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, the block adds:
  - output o_stall_cnt [31:0], counting cycles with o_stall=1 and i_enable=1;
  - output o_fwd_cnt [31:0], counting enabled edges where either registered select is non-zero.
  - Both counters reset to 0, wrap modulo 2^32, and are readable by the debug unit.
- When undefined, neither port exists and no counter logic is generated.

Decomposition:
- Select codes go in parameters.vh: FWD_SEL_REG=2'b00, FWD_SEL_MEM=2'b01, FWD_SEL_WB=2'b10. Stall FSM state encodings go there too.
- One sub-module, fwd_src_cmp: given one source register, its use bit, and the EX/MEM entries, it outputs a select code and a load-use hit.
- fwd_src_cmp is instantiated twice, once for rs and once for rt.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with random inputs -> all selects 2'b00, stall=0, bubble=0.
- EX forward: add r3 then sub r5,r3,r4 back-to-back -> o_fwd_a_sel=2'b01 when sub is in EX; o_fwd_b_sel=2'b00.
- MEM forward and priority:
  - add r3; nop; or r6,r3,r3 -> both selects 2'b10.
  - add r3; add r3; or r6,r3 -> select 2'b01 (EX wins).
- Load-use: lw r2 then add r7,r2,r1 -> o_stall=o_bubble=1 for exactly one cycle; the add then executes with o_fwd_a_sel=2'b10.
- r0 and flush:
  - writes to r0 followed by readers of r0 -> selects stay 2'b00.
  - i_flush asserted together with a load-use condition -> stall=0, bubble=1, no forward from the squashed instruction.
- Freeze: drop i_enable mid load-use stall for 4 cycles -> state and selects hold, stall/bubble=0; the stall completes after i_enable returns.
